// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller slice.
//   state_t    : issue-control FSM states (RUN, FLUSH, DRAIN, HALT)
//   reg_addr_t : architectural register address at the default width
//   FCNT_W     : width of the post-redirect blocking counter (holds 1..15)
package hazard_ctrl_pkg;

  localparam int RAW_DEF = 5;
  localparam int FCNT_W  = 4;

  typedef logic [RAW_DEF-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write counters.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   inc_en, inc_rd            : one new in-flight write to inc_rd
//   cmt_we, cmt_rd            : a write to cmt_rd retired at commit
//   kill_we, kill_rd          : a write to kill_rd squashed after issue
//   rs1, rs2, rd              : lookup addresses from decode
//   rs1_busy, rs2_busy        : lookup register has writes in flight
//   rd_full                   : destination already has MAXINF writes in flight
//   all_zero                  : no register has any write in flight
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int MAXINF = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc_en,
  input  logic [RAW-1:0] inc_rd,
  input  logic           cmt_we,
  input  logic [RAW-1:0] cmt_rd,
  input  logic           kill_we,
  input  logic [RAW-1:0] kill_rd,
  input  logic [RAW-1:0] rs1,
  input  logic [RAW-1:0] rs2,
  input  logic [RAW-1:0] rd,
  output logic           rs1_busy,
  output logic           rs2_busy,
  output logic           rd_full,
  output logic           all_zero
);

  localparam int CW   = $clog2(MAXINF + 1);
  localparam int NADR = 2 ** RAW;

  // Read view over the full address space; x0 and any address beyond
  // NREG read as an always-empty counter so lookups never need a guard.
  logic [CW-1:0] cnt [NADR];
  logic [NREG-1:0] nz;

  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic [CW:0]   up;
      logic [1:0]    dn;

      // All same-cycle events on this register are netted together;
      // a net decrement below zero clamps at zero.
      always_comb begin
        up       = {1'b0, cnt_reg} + {{CW{1'b0}}, (inc_en && (inc_rd == RAW'(gi)))};
        dn       = {1'b0, (cmt_we && (cmt_rd == RAW'(gi)))}
                 + {1'b0, (kill_we && (kill_rd == RAW'(gi)))};
        cnt_next = (up > (CW+1)'(dn)) ? CW'(up - (CW+1)'(dn)) : '0;
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_next;
      end

      assign cnt[gi] = cnt_reg;
      assign nz[gi]  = |cnt_reg;
    end

    for (gi = NREG; gi < NADR; gi++) begin : g_pad
      assign cnt[gi] = '0;
    end
  endgenerate

  assign rs1_busy = (cnt[rs1] != '0);
  assign rs2_busy = (cnt[rs2] != '0);
  assign rd_full  = (cnt[rd] == CW'(MAXINF));
  assign all_zero = ~|nz;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue hazard controller: blocks issue on RAW/WAW-capacity hazards, a busy
// mul/div unit, post-redirect flush windows and debug halt draining.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   dec_valid, dec_rs1/2, _en       : decoded instruction and its source uses
//   dec_we, dec_rd, dec_md          : destination write, destination, mul/div op
//   md_done                         : mul/div result complete
//   redirect                        : taken branch/jump at execute
//   kill_we, kill_rd                : squashed issued write
//   cmt_we, cmt_rd                  : commit-stage register write
//   dbg_halt                        : debug halt request
//   iss_fire, stall_fe, stall_dec   : issue / stall controls
//   flush, halted, sb_empty         : flush pulse, halted state, nothing in flight
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int RAW       = 5,
  parameter int MAXINF    = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           dec_valid,
  input  logic [RAW-1:0] dec_rs1,
  input  logic [RAW-1:0] dec_rs2,
  input  logic           dec_rs1_en,
  input  logic           dec_rs2_en,
  input  logic           dec_we,
  input  logic [RAW-1:0] dec_rd,
  input  logic           dec_md,
  input  logic           md_done,
  input  logic           redirect,
  input  logic           kill_we,
  input  logic [RAW-1:0] kill_rd,
  input  logic           cmt_we,
  input  logic [RAW-1:0] cmt_rd,
  input  logic           dbg_halt,
  output logic           iss_fire,
  output logic           stall_fe,
  output logic           stall_dec,
  output logic           flush,
  output logic           halted,
  output logic           sb_empty
);

  state_t              state_reg, state_next;
  logic [FCNT_W-1:0]   fcnt_reg, fcnt_next;
  logic                md_busy_reg, md_busy_next;
  logic                rs1_busy, rs2_busy, rd_full, all_zero;
  logic                hazard;

  hazard_scoreboard #(
    .NREG   (NREG),
    .RAW    (RAW),
    .MAXINF (MAXINF)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (iss_fire & dec_we),
    .inc_rd   (dec_rd),
    .cmt_we   (cmt_we),
    .cmt_rd   (cmt_rd),
    .kill_we  (kill_we),
    .kill_rd  (kill_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_full  (rd_full),
    .all_zero (all_zero)
  );

  // Registered counts only: a commit in this cycle does not release the
  // hazard until the next cycle.
  assign hazard    = (dec_rs1_en & rs1_busy) | (dec_rs2_en & rs2_busy) | (dec_we & rd_full);
  assign iss_fire  = dec_valid & (state_reg == ST_RUN) & ~redirect & ~hazard & ~md_busy_reg;
  assign stall_dec = dec_valid & ~iss_fire;
  assign stall_fe  = stall_dec | (state_reg != ST_RUN);
  assign flush     = redirect;
  assign halted    = (state_reg == ST_HALT);
  assign sb_empty  = all_zero & ~md_busy_reg;

  // A set in the same cycle as md_done wins: the new op is now in flight.
  always_comb begin
    md_busy_next = md_busy_reg & ~md_done;
    if (iss_fire && dec_md) md_busy_next = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    unique case (state_reg)
      ST_RUN: begin
        if (redirect) begin
          state_next = ST_FLUSH;
          fcnt_next  = FCNT_W'(FLUSH_CYC);
        end else if (dbg_halt) begin
          state_next = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        // FLUSH lasts FLUSH_CYC cycles; a further redirect restarts it.
        if (redirect) begin
          fcnt_next = FCNT_W'(FLUSH_CYC);
        end else if (fcnt_reg <= FCNT_W'(1)) begin
          state_next = ST_RUN;
          fcnt_next  = '0;
        end else begin
          fcnt_next = fcnt_reg - FCNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!dbg_halt)     state_next = ST_RUN;
        else if (sb_empty) state_next = ST_HALT;
      end
      ST_HALT: begin
        if (!dbg_halt) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      fcnt_reg    <= '0;
      md_busy_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fcnt_reg    <= fcnt_next;
      md_busy_reg <= md_busy_next;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int NREG      = 32;
  localparam int RAW       = 5;
  localparam int MAXINF    = 4;
  localparam int FLUSH_CYC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           dec_valid, dec_rs1_en, dec_rs2_en, dec_we, dec_md;
  logic [RAW-1:0] dec_rs1, dec_rs2, dec_rd, kill_rd, cmt_rd;
  logic           md_done, redirect, kill_we, cmt_we, dbg_halt;
  logic           iss_fire, stall_fe, stall_dec, flush, halted, sb_empty;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NREG(NREG), .RAW(RAW), .MAXINF(MAXINF), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
    .dec_we(dec_we), .dec_rd(dec_rd), .dec_md(dec_md),
    .md_done(md_done), .redirect(redirect),
    .kill_we(kill_we), .kill_rd(kill_rd),
    .cmt_we(cmt_we), .cmt_rd(cmt_rd), .dbg_halt(dbg_halt),
    .iss_fire(iss_fire), .stall_fe(stall_fe), .stall_dec(stall_dec),
    .flush(flush), .halted(halted), .sb_empty(sb_empty)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: in-flight write count per register, mul/div busy, and the
  // control mode kept as "flush cycles left" plus draining/halted flags.
  int cnt_m [NREG];
  bit md_m;
  int flush_left;
  bit draining;
  bit halted_m;

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0b, expected %0b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle();
    rst = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
    dec_rs1_en = 1'b0; dec_rs2_en = 1'b0; dec_we = 1'b0; dec_rd = '0;
    dec_md = 1'b0; md_done = 1'b0; redirect = 1'b0; kill_we = 1'b0;
    kill_rd = '0; cmt_we = 1'b0; cmt_rd = '0; dbg_halt = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Checks all outputs for the current inputs, then steps the model
  // across the coming rising edge.
  task automatic eval();
    bit hz, run, fire, sbe;
    int v, rd_i, rs1_i, rs2_i, cm_i, kl_i;
    @(negedge clk);
    rd_i  = int'(dec_rd);
    rs1_i = int'(dec_rs1);
    rs2_i = int'(dec_rs2);
    cm_i  = int'(cmt_rd);
    kl_i  = int'(kill_rd);
    hz   = (dec_rs1_en && cnt_m[rs1_i] != 0) || (dec_rs2_en && cnt_m[rs2_i] != 0)
        || (dec_we && cnt_m[rd_i] == MAXINF);
    run  = (flush_left == 0) && !draining && !halted_m;
    fire = dec_valid && run && !redirect && !hz && !md_m;
    sbe  = !md_m;
    for (int r = 0; r < NREG; r++) if (cnt_m[r] != 0) sbe = 1'b0;

    check("iss_fire",  iss_fire,  fire);
    check("stall_dec", stall_dec, dec_valid && !fire);
    check("stall_fe",  stall_fe,  (dec_valid && !fire) || !run);
    check("flush",     flush,     redirect);
    check("halted",    halted,    halted_m);
    check("sb_empty",  sb_empty,  sbe);
    $display("[TB] cyc %0d rst=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b redir=%0b dbg=%0b -> fire=%0b sfe=%0b sdec=%0b halted=%0b sbe=%0b",
             cyc, rst, dec_valid, dec_rs1, dec_rs1_en, dec_rs2, dec_rs2_en, dec_rd, dec_we,
             redirect, dbg_halt, iss_fire, stall_fe, stall_dec, halted, sb_empty);

    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
      md_m = 1'b0; flush_left = 0; draining = 1'b0; halted_m = 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        v = cnt_m[r];
        if (fire && dec_we && rd_i == r) v++;
        if (cmt_we && cm_i == r) v--;
        if (kill_we && kl_i == r) v--;
        cnt_m[r] = (v < 0) ? 0 : v;
      end
      if (md_done) md_m = 1'b0;
      if (fire && dec_md) md_m = 1'b1;
      if (run) begin
        if (redirect) flush_left = FLUSH_CYC;
        else if (dbg_halt) draining = 1'b1;
      end else if (flush_left > 0) begin
        if (redirect) flush_left = FLUSH_CYC;
        else flush_left--;
      end else if (draining) begin
        if (!dbg_halt) draining = 1'b0;
        else if (sbe) begin draining = 1'b0; halted_m = 1'b1; end
      end else if (halted_m && !dbg_halt) begin
        halted_m = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    eval();
    check("rst_fire",   iss_fire, 1'b0);
    check("rst_halted", halted,   1'b0);
    advance();
    rst = 1'b0;
    eval();
    check("rst_sbe", sb_empty, 1'b1);
    advance();
  endtask

  task automatic issue_write(input logic [RAW-1:0] r);
    idle();
    dec_valid = 1'b1; dec_we = 1'b1; dec_rd = r;
    eval();
    advance();
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
    md_m = 1'b0; flush_left = 0; draining = 1'b0; halted_m = 1'b0;
    idle();
    rst = 1'b1;
    advance();

    // RAW on x5: stalls until the commit is visible in the registered count.
    do_reset();
    issue_write(5'd5);
    idle(); dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs1_en = 1'b1;
    eval(); check("raw_stall", stall_dec, 1'b1); advance();
    cmt_we = 1'b1; cmt_rd = 5'd5;
    eval(); check("raw_nobypass", stall_dec, 1'b1); advance();
    cmt_we = 1'b0;
    eval(); check("raw_release", iss_fire, 1'b1); advance();

    // Capacity: a fifth in-flight write to x7 stalls; one commit frees it.
    do_reset();
    for (int i = 0; i < 4; i++) issue_write(5'd7);
    idle(); dec_valid = 1'b1; dec_we = 1'b1; dec_rd = 5'd7;
    eval(); check("cap_stall", stall_dec, 1'b1); advance();
    cmt_we = 1'b1; cmt_rd = 5'd7;
    eval(); check("cap_stall2", iss_fire, 1'b0); advance();
    cmt_we = 1'b0;
    eval(); check("cap_issue", iss_fire, 1'b1); advance();

    // Redirect and a restarting redirect mid-flush.
    do_reset();
    idle(); dec_valid = 1'b1; redirect = 1'b1;
    eval(); check("fl_flush", flush, 1'b1); check("fl_fire0", iss_fire, 1'b0); advance();
    redirect = 1'b0;
    eval(); check("fl_blk1", iss_fire, 1'b0); advance();
    redirect = 1'b1;
    eval(); check("fl_flush2", flush, 1'b1); advance();
    redirect = 1'b0;
    eval(); check("fl_blk2", iss_fire, 1'b0); advance();
    eval(); check("fl_blk3", iss_fire, 1'b0); advance();
    eval(); check("fl_resume", iss_fire, 1'b1); advance();

    // Simultaneous kill and commit on x3 with two in flight.
    do_reset();
    issue_write(5'd3);
    issue_write(5'd3);
    idle(); kill_we = 1'b1; kill_rd = 5'd3; cmt_we = 1'b1; cmt_rd = 5'd3;
    eval(); check("kc_busy", sb_empty, 1'b0); advance();
    idle();
    eval(); check("kc_empty", sb_empty, 1'b1); advance();

    // Debug halt while mul/div busy.
    do_reset();
    idle(); dec_valid = 1'b1; dec_md = 1'b1;
    eval(); check("md_issue", iss_fire, 1'b1); advance();
    idle(); dbg_halt = 1'b1;
    eval(); advance();
    eval(); check("dr_halted0", halted, 1'b0); check("dr_sfe", stall_fe, 1'b1); advance();
    md_done = 1'b1;
    eval(); advance();
    md_done = 1'b0;
    eval(); check("dr_sbe", sb_empty, 1'b1); advance();
    eval(); check("ht_halted", halted, 1'b1); advance();
    dbg_halt = 1'b0;
    eval(); check("ht_hold", halted, 1'b1); advance();
    eval(); check("ht_run", halted, 1'b0); check("ht_sfe", stall_fe, 1'b0); advance();

    // Reset during FLUSH with x9 busy.
    do_reset();
    for (int i = 0; i < 3; i++) issue_write(5'd9);
    idle(); redirect = 1'b1;
    eval(); advance();
    idle(); rst = 1'b1;
    eval(); advance();
    idle(); dec_valid = 1'b1; dec_rs1 = 5'd9; dec_rs1_en = 1'b1;
    eval(); check("rf_fire", iss_fire, 1'b1); check("rf_sbe", sb_empty, 1'b1); advance();

    // Randomized traffic over a small register window to provoke hazards.
    idle();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      dec_valid  = ($urandom_range(0, 3) != 0);
      dec_rs1    = RAW'($urandom_range(0, 7));
      dec_rs2    = RAW'($urandom_range(0, 7));
      dec_rd     = RAW'($urandom_range(0, 7));
      dec_rs1_en = 1'($urandom);
      dec_rs2_en = 1'($urandom);
      dec_we     = 1'($urandom);
      dec_md     = ($urandom_range(0, 7) == 0);
      md_done    = ($urandom_range(0, 4) == 0);
      redirect   = ($urandom_range(0, 9) == 0);
      kill_we    = ($urandom_range(0, 9) == 0);
      kill_rd    = RAW'($urandom_range(0, 7));
      cmt_we     = ($urandom_range(0, 9) < 4);
      cmt_rd     = RAW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3) dbg_halt = ~dbg_halt;
      eval();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
